// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory load/store unit.
//   SIZE_*  : access size encodings carried on req_size
//   state_t : load/store FSM states
//   req_t   : request as held for the duration of one transaction
package dmem_pkg;

   localparam logic [1:0] SIZE_B   = 2'b00;
   localparam logic [1:0] SIZE_H   = 2'b01;
   localparam logic [1:0] SIZE_W   = 2'b10;
   localparam logic [1:0] SIZE_ILL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RMW_RD,
      ST_STORE,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational lane steering for the load/store unit.
//   i_size  : access size (SIZE_B/H/W)
//   i_uns   : zero-extend loads instead of sign-extend
//   i_off   : byte offset within the word (addr[1:0])
//   i_word  : word read from memory
//   i_wdata : right-aligned store data
//   o_load  : extracted and extended load value
//   o_merge : i_word with the store lane replaced (full i_wdata for words)
// Offsets are masked to the access size: halves use only i_off[1], words
// ignore i_off entirely.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte  = i_word[{i_off, 3'b000} +: 8];
      w_half  = i_off[1] ? i_word[31:16] : i_word[15:0];
      o_load  = i_word;
      o_merge = i_wdata;
      case (i_size)
         SIZE_B: begin
            o_load  = {{24{w_byte[7] & ~i_uns}}, w_byte};
            o_merge = i_word;
            o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
         end
         SIZE_H: begin
            o_load  = {{16{w_half[15] & ~i_uns}}, w_half};
            o_merge = i_word;
            if (i_off[1]) o_merge[31:16] = i_wdata[15:0];
            else          o_merge[15:0]  = i_wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of the data port of a memory with
// combinational read and synchronous write, no byte enables. Sub-word
// stores are read-modify-write.
//   clk, reset_n               : clock, async active-low reset
//   req_valid/req_ready        : request handshake (accepted only in IDLE)
//   req_we/size/unsigned/addr/wdata : request fields
//   rsp_valid/rsp_ready        : response handshake
//   rsp_rdata, rsp_err         : extended load data (0 for stores/errors), error flag
//   mem_addr/mem_we/mem_d/mem_q : memory port 1
// Optional: DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into
// errors; when undefined, low address bits are masked to the access size.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | ready; latch request and classify it
// ST_LOAD   | sample mem_q, register extended load data
// ST_RMW_RD | sample mem_q, register merged word for a sub-word store
// ST_STORE  | mem_we high for this single cycle
// ST_RESP   | rsp_valid high until rsp_ready
module dmem_lsu
   import dmem_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 12
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [AWIDTH-1:0] mem_addr,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_d,
   input  logic [DWIDTH-1:0] mem_q
);

   state_t      r_state;
   state_t      w_state_nxt;
   req_t        r_req;
   logic [31:0] r_rdata;
   logic        r_err;
   logic        w_misaligned;
   logic        w_illegal;
   logic [31:0] w_load;
   logic [31:0] w_merge;
   logic        w_unused;

   always_comb begin
      w_misaligned = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      w_misaligned = (req_size == SIZE_H && req_addr[0]) ||
                     (req_size == SIZE_W && req_addr[1:0] != 2'b00);
`endif
      w_illegal = (req_size == SIZE_ILL) || (req_addr[31:AWIDTH+2] != '0) || w_misaligned;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      mem_we      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_illegal)             w_state_nxt = ST_RESP;
               else if (!req_we)          w_state_nxt = ST_LOAD;
               else if (req_size == SIZE_W) w_state_nxt = ST_STORE;
               else                       w_state_nxt = ST_RMW_RD;
            end
         end
         ST_LOAD:   w_state_nxt = ST_RESP;
         ST_RMW_RD: w_state_nxt = ST_STORE;
         ST_STORE: begin
            mem_we      = 1'b1;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // The write word lives in r_req.wdata: the raw store data for word
   // stores, overwritten with the merged word during RMW_RD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_req   <= '{we: req_we, size: req_size, uns: req_unsigned,
                               addr: req_addr, wdata: req_wdata};
                  r_rdata <= '0;
                  r_err   <= w_illegal;
               end
            end
            ST_LOAD:   r_rdata     <= w_load;
            ST_RMW_RD: r_req.wdata <= w_merge;
            default: ;
         endcase
      end
   end

   dmem_lane_align u_lane (
      .i_size  (r_req.size),
      .i_uns   (r_req.uns),
      .i_off   (r_req.addr[1:0]),
      .i_word  (mem_q),
      .i_wdata (r_req.wdata),
      .o_load  (w_load),
      .o_merge (w_merge)
   );

   assign mem_addr  = r_req.addr[AWIDTH+1:2];
   assign mem_d     = r_req.wdata;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // Direction and upper address bits are only needed at accept time.
   assign w_unused = ^{r_req.we, r_req.addr[31:AWIDTH+2]};

endmodule
